kmp_prefix_builder: RTL and testbench

Preprocessing engine for the KMP text search. It reads the search pattern one character at a time and computes the KMP failure table T[0..len], using the signed convention T[0] = −1. A negative entry means "advance text, restart pattern". Each entry is written out through a table write port into the table memory that the search controller later reads. It runs once per new pattern, before the search controller is started.

---
 rtl/kmp_pkg.sv | 26 ++
 rtl/kmp_tbl_shadow.sv | 28 ++
 rtl/kmp_prefix_builder.sv | 163 ++++++++++++++++
 tb/tb_kmp_prefix_builder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmp_pkg.sv
// Shared definitions for the KMP preprocessing and search engines.
package kmp_pkg;

  localparam int unsigned PAT_MAX_DEF = 16;
  localparam int unsigned CHAR_W_DEF  = 8;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_CHK   = 4'd2,
    ST_RDP   = 4'd3,
    ST_CMP   = 4'd4,
    ST_FAIL  = 4'd5,
    ST_FCHK  = 4'd6,
    ST_ADV   = 4'd7,
    ST_FINAL = 4'd8,
    ST_DONE  = 4'd9,
    ST_REJ   = 4'd10
  } kmp_state_t;

  // Address width able to index 0..n inclusive.
  function automatic int unsigned clog2p1(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/kmp_tbl_shadow.sv
// Read-back copy of the failure table: one write port, one combinational read port.
module kmp_tbl_shadow #(
  parameter int unsigned DEPTH = 17,
  parameter int unsigned AW    = 5,
  parameter int unsigned W     = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/kmp_prefix_builder.sv
// Builds the signed KMP failure table T[0..len] (T[0] = -1) from a pattern read one character at a time.
module kmp_prefix_builder
  import kmp_pkg::*;
#(
  parameter int unsigned PAT_MAX = PAT_MAX_DEF,
  parameter int unsigned CHAR_W  = CHAR_W_DEF,
  parameter int unsigned AW      = clog2p1(PAT_MAX),
  parameter int unsigned TW      = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     pat_len,
  output logic [AW-1:0]     pat_addr,
  input  logic [CHAR_W-1:0] pat_char,
  output logic              t_we,
  output logic [AW-1:0]     t_addr,
  output logic [TW-1:0]     t_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        actual_state
);

  localparam int unsigned DEPTH = PAT_MAX + 1;

  kmp_state_t           state;
  logic [AW-1:0]        len;
  logic [AW-1:0]        pos;
  logic signed [TW-1:0] cnd;
  logic [CHAR_W-1:0]    cp;
  logic [TW-1:0]        tbl_rd;
  logic signed [TW-1:0] cnd_back;
  logic                 char_eq;

  assign char_eq      = (pat_char == cp);
  assign cnd_back     = $signed(tbl_rd);
  assign actual_state = state;

  kmp_tbl_shadow #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .W    (TW)
  ) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .we     (t_we),
    .wr_addr(t_addr),
    .wr_data(t_data),
    .rd_addr(cnd[AW-1:0]),
    .rd_data(tbl_rd)
  );

  // The CMP entry depends on the same-cycle pattern compare, so the write port is decoded from the state register.
  always_comb begin
    t_we   = 1'b0;
    t_addr = '0;
    t_data = '0;
    case (state)
      ST_INIT: begin
        t_we   = 1'b1;
        t_data = '1;
      end
      ST_CMP: begin
        t_we   = 1'b1;
        t_addr = pos;
        t_data = char_eq ? tbl_rd : cnd;
      end
      ST_FINAL: begin
        t_we   = 1'b1;
        t_addr = len;
        t_data = cnd;
      end
      default: ;
    endcase
  end

  // pat_addr is registered one state ahead so the character is valid throughout RDP, CMP and FCHK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      pos      <= '0;
      cnd      <= '0;
      cp       <= '0;
      pat_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      pat_addr <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (pat_len == '0 || pat_len > AW'(PAT_MAX)) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ST_REJ;
            end else begin
              len   <= pat_len;
              state <= ST_INIT;
            end
          end
        end
        ST_INIT: begin
          pos   <= AW'(1);
          cnd   <= '0;
          state <= ST_CHK;
        end
        ST_CHK: begin
          if (pos == len) begin
            state <= ST_FINAL;
          end else begin
            pat_addr <= pos;
            state    <= ST_RDP;
          end
        end
        ST_RDP: begin
          cp       <= pat_char;
          pat_addr <= cnd[AW-1:0];
          state    <= ST_CMP;
        end
        ST_CMP: begin
          state <= char_eq ? ST_ADV : ST_FAIL;
        end
        ST_FAIL: begin
          cnd <= cnd_back;
          if (!cnd_back[TW-1]) pat_addr <= cnd_back[AW-1:0];
          state <= ST_FCHK;
        end
        ST_FCHK: begin
          if (cnd[TW-1] || char_eq) state <= ST_ADV;
          else                      state <= ST_FAIL;
        end
        ST_ADV: begin
          pos   <= pos + AW'(1);
          cnd   <= cnd + TW'(1);
          state <= ST_CHK;
        end
        ST_FINAL: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_REJ: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmp_prefix_builder.sv
// Scoreboard bench for kmp_prefix_builder: a software KMP model predicts every table write and the latency.
module tb_kmp_prefix_builder;

  localparam int AW = 5;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] pat_len;
  logic [AW-1:0] pat_addr;
  logic [7:0]    pat_char;
  logic          t_we;
  logic [AW-1:0] t_addr;
  logic [TW-1:0] t_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [3:0]    actual_state;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [TW-1:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] pat_mem [0:16];
  int         vectors     = 0;
  int         miscompares = 0;
  int         fail_visits = 0;
  int         fchk_visits = 0;

  always #5 clk = ~clk;

  assign pat_char = (pat_addr <= 5'd16) ? pat_mem[pat_addr] : 8'h00;

  kmp_prefix_builder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pat_len     (pat_len),
    .pat_addr    (pat_addr),
    .pat_char    (pat_char),
    .t_we        (t_we),
    .t_addr      (t_addr),
    .t_data      (t_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .actual_state(actual_state)
  );

  // Write-port monitor: pops the scoreboard on every strobe and polices idle port values.
  always @(negedge clk) begin
    if (!rst) begin
      if (actual_state == 4'd5) fail_visits++;
      if (actual_state == 4'd6) fchk_visits++;
      vectors++;
      if (t_we) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d, none expected", t_addr, $signed(t_data));
        end else begin
          mon_e = exp_q.pop_front();
          if ({t_addr, t_data} !== mon_e) begin
            miscompares++;
            $display("FAIL table_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                     t_addr, $signed(t_data), mon_e.a, $signed(mon_e.d));
          end
        end
      end else if (t_addr !== '0 || t_data !== '0) begin
        miscompares++;
        $display("FAIL idle_port: got addr=%0d data=%0d, expected 0/0", t_addr, t_data);
      end
      if (!(actual_state inside {4'd3, 4'd4, 4'd6}) && pat_addr !== '0) begin
        vectors++;
        miscompares++;
        $display("FAIL pat_addr_idle: got %0d in state %0d, expected 0", pat_addr, actual_state);
      end
    end
  end

  task automatic load_pattern(input string s);
    for (int i = 0; i < 17; i++) pat_mem[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  // Reference KMP table construction; fails counts the cnd <- T[cnd] steps.
  task automatic push_model(input string s, output int fails);
    int t[17];
    int p;
    int c;
    int l;
    l = s.len();
    t[0] = -1;
    p = 1;
    c = 0;
    fails = 0;
    while (p < l) begin
      if (s[p] == s[c]) begin
        t[p] = t[c];
      end else begin
        t[p] = c;
        while (c >= 0) begin
          if (s[p] == s[c]) break;
          c = t[c];
          fails++;
        end
      end
      p++;
      c++;
    end
    t[l] = c;
    for (int i = 0; i <= l; i++) exp_q.push_back(wr_t'{a: AW'(i), d: TW'(t[i])});
  endtask

  // Caller is away from a rising edge; start is raised immediately.
  task automatic do_run(input string name, input string s, input int mid_start, output int lat);
    int fails;
    int n;
    int exp_lat;
    bit got;
    load_pattern(s);
    push_model(s, fails);
    fail_visits = 0;
    fchk_visits = 0;
    start   = 1'b1;
    pat_len = AW'(s.len());
    @(posedge clk);
    #1 start = 1'b0;
    pat_len = '0;
    n = 0;
    got = 1'b0;
    while (n < 400 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s busy_rise: got %b, expected 1", name, busy);
        end
      end
      if (n == mid_start) begin
        start   = 1'b1;
        pat_len = AW'(3);
      end else if (n == mid_start + 1) begin
        start   = 1'b0;
        pat_len = '0;
      end
      if (done === 1'b1) got = 1'b1;
    end
    lat = n;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s done_timeout: no done after %0d cycles", name, n);
    end else begin
      exp_lat = 4 + 4 * (s.len() - 1) + 2 * fails;
      if (n !== exp_lat) begin
        miscompares++;
        $display("FAIL %s latency: got %0d, expected %0d", name, n, exp_lat);
      end
      vectors++;
      if (err !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s done_flags: got err=%b busy=%b, expected err=0 busy=1", name, err, busy);
      end
      vectors++;
      if (exp_q.size() !== 0) begin
        miscompares++;
        $display("FAIL %s missing_writes: got %0d outstanding, expected 0", name, exp_q.size());
      end
      vectors++;
      if (fail_visits !== fails) begin
        miscompares++;
        $display("FAIL %s fail_visits: got %0d, expected %0d", name, fail_visits, fails);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || actual_state !== 4'd0) begin
        miscompares++;
        $display("FAIL %s after_done: got done=%b busy=%b state=%0d, expected 0/0/0",
                 name, done, busy, actual_state);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b0;
    pat_len = '0;
    load_pattern("");
    #3;
    vectors++;
    if ({busy, done, err, t_we, t_addr, t_data, pat_addr, actual_state} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b we=%b state=%0d, expected all 0",
               busy, done, err, t_we, actual_state);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_abcdabd();
    int lat;
    do_run("abcdabd", "ABCDABD", 0, lat);
  endtask

  task automatic test_aaaa();
    int lat;
    do_run("aaaa", "AAAA", 0, lat);
    vectors++;
    if (lat !== 16 || fail_visits !== 0) begin
      miscompares++;
      $display("FAIL aaaa_timing: got lat=%0d fail_visits=%0d, expected 16/0", lat, fail_visits);
    end
  endtask

  task automatic test_abab();
    int lat;
    do_run("abab", "ABAB", 0, lat);
    vectors++;
    if (fail_visits !== 1 || fchk_visits !== 1) begin
      miscompares++;
      $display("FAIL abab_visits: got fail=%0d fchk=%0d, expected 1/1", fail_visits, fchk_visits);
    end
  endtask

  task automatic test_reject();
    logic [AW-1:0] lens[2];
    lens[0] = AW'(0);
    lens[1] = AW'(17);
    for (int k = 0; k < 2; k++) begin
      start   = 1'b1;
      pat_len = lens[k];
      @(posedge clk);
      #1 start = 1'b0;
      pat_len = '0;
      @(negedge clk);
      vectors++;
      if (done !== 1'b1 || err !== 1'b1 || actual_state !== 4'd10 || t_we !== 1'b0) begin
        miscompares++;
        $display("FAIL reject_%0d: got done=%b err=%b state=%0d we=%b, expected 1/1/10/0",
                 lens[k], done, err, actual_state, t_we);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || err !== 1'b0 || actual_state !== 4'd0) begin
        miscompares++;
        $display("FAIL reject_after_%0d: got done=%b err=%b state=%0d, expected 0/0/0",
                 lens[k], done, err, actual_state);
      end
    end
  endtask

  task automatic test_len1();
    int lat;
    do_run("len1", "A", 0, lat);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL len1_latency: got %0d, expected 4", lat);
    end
  endtask

  task automatic test_start_while_busy();
    int lat_a;
    int lat_b;
    do_run("busy_ref", "ABCAABCAB", 0, lat_a);
    do_run("busy_start", "ABCAABCAB", 10, lat_b);
    vectors++;
    if (lat_b !== lat_a) begin
      miscompares++;
      $display("FAIL busy_start_latency: got %0d, expected %0d", lat_b, lat_a);
    end
  endtask

  task automatic test_rst_mid();
    int fails;
    int n;
    int lat;
    load_pattern("ABCDABD");
    push_model("ABCDABD", fails);
    start   = 1'b1;
    pat_len = AW'(7);
    @(posedge clk);
    #1 start = 1'b0;
    pat_len = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (actual_state !== 4'd5 && n < 100);
    vectors++;
    if (actual_state !== 4'd5) begin
      miscompares++;
      $display("FAIL rst_mid_reach_fail: got state=%0d, expected 5", actual_state);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, err, t_we, t_addr, t_data, pat_addr, actual_state} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b we=%b addr=%0d state=%0d, expected all 0",
               busy, done, t_we, pat_addr, actual_state);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_run("after_rst", "ABCDABD", 0, lat);
  endtask

  initial begin
    test_reset();
    test_abcdabd();
    test_aaaa();
    test_abab();
    test_reject();
    test_len1();
    test_start_while_busy();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
